// File: rtl/shift_pkg.sv
// Shared encodings for the shift arbiter: shift opcodes, port identifiers and datapath sizes.
package shift_pkg;

    localparam int SH_WIDTH = 32;
    localparam int SH_AMT_W = 5;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRA = 2'b01,
        SH_SRL = 2'b10,
        SH_RSV = 2'b11
    } shift_op_e;

    localparam logic PORT_ALU = 1'b0;
    localparam logic PORT_MD  = 1'b1;

endpackage

// File: rtl/shift_core.sv
// Combinational shift datapath: one left shifter and one arithmetic right shifter whose
// sign-fill bit is forced to zero for SRL, so both right shifts share a single unit.
module shift_core
    import shift_pkg::*;
(
    input  shift_op_e              op,
    input  logic [SH_WIDTH-1:0]    data,
    input  logic [SH_AMT_W-1:0]    amt,
    output logic [SH_WIDTH-1:0]    result,
    output logic                   err
);

    logic [SH_WIDTH-1:0] left_s;
    logic [SH_WIDTH-1:0] right_s;
    logic                fill_s;

    assign left_s  = data << amt;
    assign fill_s  = (op == SH_SRA) ? data[SH_WIDTH-1] : 1'b0;
    // A 33-bit signed shift lets the extra top bit supply the fill for both SRA and SRL.
    assign right_s = SH_WIDTH'($signed({fill_s, data}) >>> amt);

    // Output select by opcode; reserved opcode yields zero data and raises err.
    always_comb begin
        result = {SH_WIDTH{1'b0}};
        err    = 1'b0;
        case (op)
            SH_SLL:  result = left_s;
            SH_SRA:  result = right_s;
            SH_SRL:  result = right_s;
            SH_RSV:  err    = 1'b1;
            default: err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of a shared shift datapath, with a single registered result
// slot under valid/ready backpressure and one cycle from accept to rsp_valid.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int RR_EN = 1,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [4:0]       req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [4:0]       req1_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    logic             slot_free_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             grant_any_s;
    logic [1:0]       sel_op_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [4:0]       sel_amt_s;
    logic [WIDTH-1:0] core_result_s;
    logic             core_err_s;

    logic             last_grant_r;
    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_err_r;

    assign slot_free_s = ~rsp_valid_r | rsp_ready;
    assign grant_any_s = grant0_s | grant1_s;

    // Grant decision: single requester wins outright; on a tie, round-robin or port 0.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (slot_free_s) begin
            if (req0_valid && req1_valid) begin
                if ((RR_EN != 0) && (last_grant_r == PORT_ALU)) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
        end
    end

    // Operand mux feeding the shared shifter from the granted port.
    always_comb begin
        sel_op_s   = req0_op;
        sel_data_s = req0_data;
        sel_amt_s  = req0_amt;
        if (grant1_s) begin
            sel_op_s   = req1_op;
            sel_data_s = req1_data;
            sel_amt_s  = req1_amt;
        end else begin
            sel_op_s   = req0_op;
        end
    end

    shift_core u_core (
        .op     (shift_op_e'(sel_op_s)),
        .data   (sel_data_s),
        .amt    (sel_amt_s),
        .result (core_result_s),
        .err    (core_err_s)
    );

    // Result slot and last-grant history; an accept overrides a simultaneous drain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_r <= PORT_MD;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_data_r   <= {WIDTH{1'b0}};
            rsp_err_r    <= 1'b0;
        end else if (grant_any_s) begin
            last_grant_r <= grant1_s;
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= grant1_s;
            rsp_data_r   <= core_result_s;
            rsp_err_r    <= core_err_s;
        end else if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench: two arbiters (round-robin and fixed priority) share one stimulus stream
// and are each checked against a behavioural model of arbitration and shifting.
module tb_shift_arbiter;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic [31:0] req0_data = 32'h0, req1_data = 32'h0;
    logic [4:0]  req0_amt = 5'd0, req1_amt = 5'd0;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rv   [2];
    logic        rid  [2];
    logic        rerr [2];
    logic [31:0] rdat [2];

    exp_t        q [2][$];
    bit          mvalid [2];
    int          mlast  [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    shift_arbiter #(.RR_EN(1), .WIDTH(32)) dut_rr (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_op(req0_op),
        .req0_data(req0_data), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_op(req1_op),
        .req1_data(req1_data), .req1_amt(req1_amt),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]),
        .rsp_data(rdat[0]), .rsp_err(rerr[0])
    );

    shift_arbiter #(.RR_EN(0), .WIDTH(32)) dut_fp (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_op(req0_op),
        .req0_data(req0_data), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_op(req1_op),
        .req1_data(req1_data), .req1_amt(req1_amt),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]),
        .rsp_data(rdat[1]), .rsp_err(rerr[1])
    );

    function automatic exp_t shift_ref(input logic id, input logic [1:0] op,
                                       input logic [31:0] d, input logic [4:0] a);
        exp_t e;
        longint unsigned v;
        e.id  = id;
        e.err = 1'b0;
        v     = longint'(d);
        case (op)
            2'b00:   e.data = 32'((v * (64'd1 << a)) & 64'hFFFF_FFFF);
            2'b01:   e.data = d[31] ? ~32'((~v & 64'hFFFF_FFFF) / (64'd1 << a))
                                    : 32'(v / (64'd1 << a));
            2'b10:   e.data = 32'(v / (64'd1 << a));
            default: begin e.data = 32'h0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One cycle: drive inputs, check readies against the model, record the accept.
    task automatic step(input logic v0, input logic [1:0] o0, input logic [31:0] d0, input logic [4:0] a0,
                        input logic v1, input logic [1:0] o1, input logic [31:0] d1, input logic [4:0] a1,
                        input logic rr);
        int g [2];
        req0_valid = v0; req0_op = o0; req0_data = d0; req0_amt = a0;
        req1_valid = v1; req1_op = o1; req1_data = d1; req1_amt = a1;
        rsp_ready  = rr;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            g[k] = -1;
            if (!mvalid[k] || rr) begin
                if (v0 && v1) g[k] = (k == 0 && mlast[k] == 0) ? 1 : 0;
                else if (v0)  g[k] = 0;
                else if (v1)  g[k] = 1;
            end
            check($sformatf("req0_ready[%0d]", k), longint'(rdy0[k]), longint'(g[k] == 0));
            check($sformatf("req1_ready[%0d]", k), longint'(rdy1[k]), longint'(g[k] == 1));
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            if (g[k] == 0) begin
                q[k].push_back(shift_ref(1'b0, o0, d0, a0));
                mlast[k] = 0; mvalid[k] = 1'b1;
            end else if (g[k] == 1) begin
                q[k].push_back(shift_ref(1'b1, o1, d1, a1));
                mlast[k] = 1; mvalid[k] = 1'b1;
            end else if (rr) begin
                mvalid[k] = 1'b0;
            end
        end
        #1;
    endtask

    // Monitor: compares the presented result with the queue head and pops on handshake.
    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rsp_valid[%0d]", k), longint'(rv[k]), longint'(q[k].size() > 0));
                if (rv[k] && q[k].size() > 0) begin
                    check($sformatf("rsp_id[%0d]", k),   longint'(rid[k]),  longint'(q[k][0].id));
                    check($sformatf("rsp_data[%0d]", k), longint'(rdat[k]), longint'(q[k][0].data));
                    check($sformatf("rsp_err[%0d]", k),  longint'(rerr[k]), longint'(q[k][0].err));
                    if (rsp_ready) void'(q[k].pop_front());
                end
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            mvalid[k] = 1'b0;
            mlast[k]  = 1;
        end
    endtask

    initial begin
        logic [1:0] seq [4];
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            check("reset_valid", longint'(rv[k]), 0);
            check("reset_id",    longint'(rid[k]), 0);
            check("reset_data",  longint'(rdat[k]), 0);
            check("reset_err",   longint'(rerr[k]), 0);
        end
        @(posedge clock); #1;
        reset = 1'b0;

        // Both ports valid from reset: round-robin 0,1,0,1; fixed priority always 0.
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd0; seq[3] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b00, $urandom, 5'($urandom), 1'b1, 2'b10, $urandom, 5'($urandom), 1'b1);
            check("rr_order", longint'(rid[0]), longint'(seq[i]));
            check("fp_order", longint'(rid[1]), 0);
        end

        step(1'b1, 2'b00, 32'h0000_0001, 5'd31, 1'b0, 2'b00, 32'h0, 5'd0, 1'b1);
        check("sll31_data", longint'(rdat[0]), longint'(32'h8000_0000));
        check("sll31_id",   longint'(rid[0]), 0);

        step(1'b0, 2'b00, 32'h0, 5'd0, 1'b1, 2'b01, 32'h8000_0010, 5'd4, 1'b1);
        check("p1_sra", longint'(rdat[0]), longint'(32'hF800_0001));
        step(1'b0, 2'b00, 32'h0, 5'd0, 1'b1, 2'b10, 32'h8000_0010, 5'd4, 1'b1);
        check("p1_srl", longint'(rdat[0]), longint'(32'h0800_0001));
        step(1'b0, 2'b00, 32'h0, 5'd0, 1'b1, 2'b01, 32'h8000_0010, 5'd0, 1'b1);
        check("p1_amt0", longint'(rdat[0]), longint'(32'h8000_0010));
        step(1'b0, 2'b00, 32'h0, 5'd0, 1'b1, 2'b11, 32'h8000_0010, 5'd4, 1'b1);
        check("p1_rsv_data", longint'(rdat[0]), 0);
        check("p1_rsv_err",  longint'(rerr[0]), 1);
        step(1'b1, 2'b01, 32'h8000_0000, 5'd31, 1'b0, 2'b00, 32'h0, 5'd0, 1'b1);
        check("sra31_neg", longint'(rdat[0]), longint'(32'hFFFF_FFFF));

        // Backpressure: slot full and not drained for 5 cycles, then drain with accept.
        step(1'b1, 2'b00, $urandom, 5'($urandom), 1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 2'($urandom), $urandom, 5'($urandom), 1'b1, 2'($urandom), $urandom, 5'($urandom), 1'b0);
        step(1'b1, 2'b10, $urandom, 5'($urandom), 1'b1, 2'b01, $urandom, 5'($urandom), 1'b1);

        for (int i = 0; i < 400; i++)
            step(1'($urandom), 2'($urandom), $urandom, 5'($urandom),
                 1'($urandom), 2'($urandom), $urandom, 5'($urandom), 1'($urandom_range(0, 3) != 0));

        // Asynchronous reset while a result is held under backpressure.
        step(1'b1, 2'b00, $urandom, 5'($urandom), 1'b1, 2'b00, $urandom, 5'($urandom), 1'b0);
        step(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_rr", longint'(rv[0]), 0);
        check("async_rst_fp", longint'(rv[1]), 0);
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        step(1'b1, 2'b00, $urandom, 5'($urandom), 1'b1, 2'b00, $urandom, 5'($urandom), 1'b1);
        check("post_rst_first", longint'(rid[0]), 0);

        for (int i = 0; i < 3; i++)
            step(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0, 5'd0, 1'b1);
        check("drained_rr", longint'(q[0].size()), 0);
        check("drained_fp", longint'(q[1].size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
